// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter for the block memory data port
// Define MEM_ARB_RR_EN for round-robin arbitration; default is CPU priority with a starvation guard.
module mem_port_arbiter #(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 16,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              CLK,
   input  logic              CtrlRst,
   input  logic              CpuReq,
   input  logic              CpuWe,
   input  logic [ADDR_W-1:0] CpuAddr,
   input  logic [DATA_W-1:0] CpuWData,
   output logic              CpuGnt,
   output logic [DATA_W-1:0] CpuRData,
   output logic              CpuValid,
   input  logic              DbgReq,
   input  logic              DbgWe,
   input  logic [ADDR_W-1:0] DbgAddr,
   input  logic [DATA_W-1:0] DbgWData,
   output logic              DbgGnt,
   output logic [DATA_W-1:0] DbgRData,
   output logic              DbgValid,
   output logic              MemEn,
   output logic              MemWe,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [DATA_W-1:0] MemWData,
   input  logic [DATA_W-1:0] MemRData,
   output logic [15:0]       CpuCount,
   output logic [15:0]       DbgCount
);

   logic cpuAccept;
   logic dbgAccept;
   logic memTag;
   logic memRd;

   assign cpuAccept = CpuReq & CpuGnt;
   assign dbgAccept = DbgReq & DbgGnt;

`ifdef MEM_ARB_RR_EN
   // lastCpu = 0 means Dbg won last, so the CPU takes the first contention after reset
   logic lastCpu;

   always_comb begin
      CpuGnt = ~CtrlRst & CpuReq & (~DbgReq | ~lastCpu);
      DbgGnt = ~CtrlRst & DbgReq & (~CpuReq | lastCpu);
   end

   always_ff @(posedge CLK) begin
      if (CtrlRst) begin
         lastCpu <= 1'b0;
      end else if (cpuAccept | dbgAccept) begin
         lastCpu <= cpuAccept;
      end
   end
`else
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

   logic [3:0] starveCnt;
   logic       forceDbg;

   assign forceDbg = (starveCnt == STARVE_LIM);

   always_comb begin
      CpuGnt = ~CtrlRst & CpuReq & ~(DbgReq & forceDbg);
      DbgGnt = ~CtrlRst & DbgReq & (~CpuReq | forceDbg);
   end

   // Counts contended CPU wins; any Dbg acceptance or idle Dbg cycle restarts the count
   always_ff @(posedge CLK) begin
      if (CtrlRst || !DbgReq || dbgAccept) begin
         starveCnt <= 4'd0;
      end else if (CpuReq && cpuAccept) begin
         starveCnt <= starveCnt + 4'd1;
      end
   end
`endif

   always_ff @(posedge CLK) begin
      if (CtrlRst) begin
         MemEn    <= 1'b0;
         MemWe    <= 1'b0;
         MemAddr  <= '0;
         MemWData <= '0;
         memTag   <= 1'b0;
         memRd    <= 1'b0;
      end else begin
         MemEn <= cpuAccept | dbgAccept;
         if (dbgAccept) begin
            MemWe    <= DbgWe;
            MemAddr  <= DbgAddr;
            MemWData <= DbgWData;
            memTag   <= 1'b1;
            memRd    <= ~DbgWe;
         end else if (cpuAccept) begin
            MemWe    <= CpuWe;
            MemAddr  <= CpuAddr;
            MemWData <= CpuWData;
            memTag   <= 1'b0;
            memRd    <= ~CpuWe;
         end else begin
            memRd    <= 1'b0;
         end
      end
   end

   // Read data is captured at the edge closing the MemEn cycle and steered by the tag
   always_ff @(posedge CLK) begin
      if (CtrlRst) begin
         CpuValid <= 1'b0;
         DbgValid <= 1'b0;
         CpuRData <= '0;
         DbgRData <= '0;
      end else begin
         CpuValid <= MemEn & memRd & ~memTag;
         DbgValid <= MemEn & memRd & memTag;
         if (MemEn && memRd && !memTag) begin
            CpuRData <= MemRData;
         end
         if (MemEn && memRd && memTag) begin
            DbgRData <= MemRData;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (CtrlRst) begin
         CpuCount <= 16'd0;
         DbgCount <= 16'd0;
      end else begin
         if (cpuAccept && CpuCount != 16'hFFFF) begin
            CpuCount <= CpuCount + 16'd1;
         end
         if (dbgAccept && DbgCount != 16'hFFFF) begin
            DbgCount <= DbgCount + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
// Honours MEM_ARB_RR_EN when selecting the expected arbitration behaviour.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   localparam int SL = 4;

   logic        CLK = 1'b0;
   logic        CtrlRst;
   logic        CpuReq, CpuWe, DbgReq, DbgWe;
   logic [15:0] CpuAddr, CpuWData, DbgAddr, DbgWData;
   logic        CpuGnt, DbgGnt, CpuValid, DbgValid;
   logic [15:0] CpuRData, DbgRData;
   logic        MemEn, MemWe;
   logic [15:0] MemAddr, MemWData, MemRData;
   logic [15:0] CpuCount, DbgCount;

   logic        pokeEn;
   logic [15:0] pokeAddr, pokeData;
   logic [15:0] ram [0:65535];

   int checks   = 0;
   int failures = 0;

   typedef struct {
      bit c;
      bit d;
      bit ec;
      bit ed;
   } vec_t;

   typedef struct {
      int          due;
      bit          who;
      logic [15:0] data;
   } ret_t;

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(SL)) dut (
      .CLK(CLK), .CtrlRst(CtrlRst),
      .CpuReq(CpuReq), .CpuWe(CpuWe), .CpuAddr(CpuAddr), .CpuWData(CpuWData),
      .CpuGnt(CpuGnt), .CpuRData(CpuRData), .CpuValid(CpuValid),
      .DbgReq(DbgReq), .DbgWe(DbgWe), .DbgAddr(DbgAddr), .DbgWData(DbgWData),
      .DbgGnt(DbgGnt), .DbgRData(DbgRData), .DbgValid(DbgValid),
      .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
      .MemRData(MemRData), .CpuCount(CpuCount), .DbgCount(DbgCount)
   );

   always #5 CLK = ~CLK;

   // Behavioural block RAM: asynchronous read, write at the edge closing the MemEn cycle
   assign MemRData = ram[MemAddr];
   always @(posedge CLK) begin
      if (MemEn && MemWe) ram[MemAddr] <= MemWData;
      if (pokeEn) ram[pokeAddr] <= pokeData;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   task automatic poke(input logic [15:0] a, input logic [15:0] d);
      @(negedge CLK);
      pokeEn = 1'b1; pokeAddr = a; pokeData = d;
      @(negedge CLK);
      pokeEn = 1'b0;
   endtask

   task automatic doReset();
      CtrlRst = 1'b1;
      CpuReq = 1'b1; DbgReq = 1'b1;
      #1;
      chk("rst_cpugnt", 32'(CpuGnt), 32'd0);
      chk("rst_dbggnt", 32'(DbgGnt), 32'd0);
      @(negedge CLK);
      CpuReq = 1'b0; DbgReq = 1'b0;
      @(negedge CLK);
      CtrlRst = 1'b0;
      chk("rst_memen",  32'(MemEn),    32'd0);
      chk("rst_memwe",  32'(MemWe),    32'd0);
      chk("rst_memadr", 32'(MemAddr),  32'd0);
      chk("rst_memwd",  32'(MemWData), 32'd0);
      chk("rst_cvalid", 32'(CpuValid), 32'd0);
      chk("rst_dvalid", 32'(DbgValid), 32'd0);
      chk("rst_crdata", 32'(CpuRData), 32'd0);
      chk("rst_drdata", 32'(DbgRData), 32'd0);
      chk("rst_ccount", 32'(CpuCount), 32'd0);
      chk("rst_dcount", 32'(DbgCount), 32'd0);
   endtask

   task automatic runTable();
      vec_t        vt [21];
      logic [0:20] cR, dR, eC, eD;
      int          nC, nD;
      cR = 21'b100_1111111111111_01110;
      dR = 21'b010_1111111111111_10111;
`ifdef MEM_ARB_RR_EN
      eC = 21'b100_1010101010101_01010;
      eD = 21'b010_0101010101010_10101;
`else
      eC = 21'b100_1111011110111_01110;
      eD = 21'b010_0000100001000_10001;
`endif
      for (int i = 0; i < 21; i++) vt[i] = '{c: cR[i], d: dR[i], ec: eC[i], ed: eD[i]};
      doReset();
      nC = 0; nD = 0;
      for (int i = 0; i < 21; i++) begin
         CpuReq = vt[i].c; CpuWe = 1'b1; CpuAddr = 16'h0300 + 16'(i); CpuWData = 16'(i);
         DbgReq = vt[i].d; DbgWe = 1'b1; DbgAddr = 16'h0340 + 16'(i); DbgWData = 16'(i);
         #1;
         chk($sformatf("tbl_cpugnt_%0d", i), 32'(CpuGnt), 32'(vt[i].ec));
         chk($sformatf("tbl_dbggnt_%0d", i), 32'(DbgGnt), 32'(vt[i].ed));
         nC += int'(vt[i].ec); nD += int'(vt[i].ed);
         @(negedge CLK);
      end
      CpuReq = 1'b0; DbgReq = 1'b0;
      @(negedge CLK);
      chk("tbl_ccount", 32'(CpuCount), 32'(nC));
      chk("tbl_dcount", 32'(DbgCount), 32'(nD));
   endtask

   task automatic runDirected();
      doReset();
      poke(16'h0010, 16'hBEEF);
      // Single CPU read
      CpuReq = 1'b1; CpuWe = 1'b0; CpuAddr = 16'h0010;
      #1 chk("rd_cpugnt", 32'(CpuGnt), 32'd1);
      @(negedge CLK);
      CpuReq = 1'b0;
      chk("rd_memen",  32'(MemEn),   32'd1);
      chk("rd_memadr", 32'(MemAddr), 32'h0010);
      chk("rd_memwe",  32'(MemWe),   32'd0);
      chk("rd_cvalid_early", 32'(CpuValid), 32'd0);
      @(negedge CLK);
      chk("rd_cvalid", 32'(CpuValid), 32'd1);
      chk("rd_crdata", 32'(CpuRData), 32'hBEEF);
      chk("rd_dvalid", 32'(DbgValid), 32'd0);
      @(negedge CLK);
      chk("rd_cvalid_pulse", 32'(CpuValid), 32'd0);
      chk("rd_crdata_hold",  32'(CpuRData), 32'hBEEF);
      // Dbg write followed immediately by read of the same address
      DbgReq = 1'b1; DbgWe = 1'b1; DbgAddr = 16'h0100; DbgWData = 16'h1234;
      #1 chk("wr_dbggnt", 32'(DbgGnt), 32'd1);
      @(negedge CLK);
      DbgWe = 1'b0; DbgWData = 16'h0000;
      #1 chk("wr_dbggnt2", 32'(DbgGnt), 32'd1);
      chk("wr_memwe", 32'(MemWe), 32'd1);
      @(negedge CLK);
      DbgReq = 1'b0;
      chk("wr_memen2", 32'(MemEn), 32'd1);
      chk("wr_memwe2", 32'(MemWe), 32'd0);
      chk("wr_dvalid_w", 32'(DbgValid), 32'd0);
      @(negedge CLK);
      chk("wr_dvalid", 32'(DbgValid), 32'd1);
      chk("wr_drdata", 32'(DbgRData), 32'h1234);
      chk("wr_dcount", 32'(DbgCount), 32'd2);
      chk("wr_cvalid", 32'(CpuValid), 32'd0);
      chk("wr_crdata_hold", 32'(CpuRData), 32'hBEEF);
      // Reset arrives while a read is in flight
      CpuReq = 1'b1; CpuWe = 1'b0; CpuAddr = 16'h0010;
      @(negedge CLK);
      CpuReq = 1'b0; CtrlRst = 1'b1;
      chk("mr_memen", 32'(MemEn), 32'd1);
      @(negedge CLK);
      chk("mr_cvalid",  32'(CpuValid), 32'd0);
      chk("mr_memen0",  32'(MemEn),    32'd0);
      chk("mr_memadr",  32'(MemAddr),  32'd0);
      chk("mr_memwe",   32'(MemWe),    32'd0);
      chk("mr_memwd",   32'(MemWData), 32'd0);
      chk("mr_ccount",  32'(CpuCount), 32'd0);
      chk("mr_dcount",  32'(DbgCount), 32'd0);
      chk("mr_crdata",  32'(CpuRData), 32'd0);
      CtrlRst = 1'b0;
      @(negedge CLK);
      chk("mr_cvalid2", 32'(CpuValid), 32'd0);
      // Counter saturation
      doReset();
      force dut.CpuCount = 16'hFFFE;
      #1 release dut.CpuCount;
      CpuReq = 1'b1; CpuWe = 1'b1; CpuAddr = 16'h0380; CpuWData = 16'h0001;
      @(negedge CLK);
      chk("sat_first", 32'(CpuCount), 32'hFFFF);
      CpuWData = 16'h0002;
      @(negedge CLK);
      CpuReq = 1'b0;
      chk("sat_second", 32'(CpuCount), 32'hFFFF);
   endtask

   task automatic runRandom(input int n);
      ret_t        q[$];
      logic [15:0] mMem [16];
      int          mCnt0, mCnt1, mStarve;
      bit          mLastCpu, cHold, dHold, egC, egD, pAcc, pWe, expCV, expDV;
      logic [15:0] lastC, lastD, pAddr, pData;
      int          idx;
      doReset();
      for (int i = 0; i < 16; i++) begin
         mMem[i] = 16'($urandom);
         poke(16'h0200 + 16'(i), mMem[i]);
      end
      mCnt0 = 0; mCnt1 = 0; mStarve = 0; mLastCpu = 1'b0;
      cHold = 1'b0; dHold = 1'b0; pAcc = 1'b0; pWe = 1'b0;
      lastC = 16'h0; lastD = 16'h0; pAddr = 16'h0; pData = 16'h0;
      for (int cyc = 0; cyc < n; cyc++) begin
         @(negedge CLK);
         expCV = 1'b0; expDV = 1'b0;
         if (q.size() > 0 && q[0].due == cyc) begin
            if (q[0].who) begin expDV = 1'b1; lastD = q[0].data; end
            else          begin expCV = 1'b1; lastC = q[0].data; end
            void'(q.pop_front());
         end
         chk("rnd_cvalid", 32'(CpuValid), 32'(expCV));
         chk("rnd_dvalid", 32'(DbgValid), 32'(expDV));
         chk("rnd_crdata", 32'(CpuRData), 32'(lastC));
         chk("rnd_drdata", 32'(DbgRData), 32'(lastD));
         chk("rnd_ccount", 32'(CpuCount), 32'(mCnt0));
         chk("rnd_dcount", 32'(DbgCount), 32'(mCnt1));
         chk("rnd_memen",  32'(MemEn),    32'(pAcc));
         if (pAcc) begin
            chk("rnd_memadr", 32'(MemAddr), 32'(pAddr));
            chk("rnd_memwe",  32'(MemWe),   32'(pWe));
            if (pWe) chk("rnd_memwd", 32'(MemWData), 32'(pData));
         end
         if (!cHold) begin
            CpuReq = ($urandom_range(0, 99) < 60); CpuWe = 1'($urandom);
            CpuAddr = 16'h0200 + 16'($urandom_range(0, 15)); CpuWData = 16'($urandom);
         end
         if (!dHold) begin
            DbgReq = ($urandom_range(0, 99) < 60); DbgWe = 1'($urandom);
            DbgAddr = 16'h0200 + 16'($urandom_range(0, 15)); DbgWData = 16'($urandom);
         end
         #1;
`ifdef MEM_ARB_RR_EN
         egC = CpuReq && (!DbgReq || !mLastCpu);
         egD = DbgReq && !egC;
`else
         egD = DbgReq && (!CpuReq || mStarve == SL);
         egC = CpuReq && !egD;
`endif
         chk("rnd_cpugnt", 32'(CpuGnt), 32'(egC));
         chk("rnd_dbggnt", 32'(DbgGnt), 32'(egD));
         pAcc = egC || egD;
         pWe   = egD ? DbgWe    : CpuWe;
         pAddr = egD ? DbgAddr  : CpuAddr;
         pData = egD ? DbgWData : CpuWData;
         if (pAcc) begin
            idx = int'(pAddr - 16'h0200);
            if (pWe) mMem[idx] = pData;
            else q.push_back('{due: cyc + 2, who: egD, data: mMem[idx]});
            if (egC && mCnt0 < 16'hFFFF) mCnt0++;
            if (egD && mCnt1 < 16'hFFFF) mCnt1++;
            mLastCpu = egC;
         end
         if (!DbgReq || egD) mStarve = 0;
         else if (CpuReq) mStarve++;
         cHold = CpuReq && !egC;
         dHold = DbgReq && !egD;
      end
      CpuReq = 1'b0; DbgReq = 1'b0;
      @(negedge CLK);
   endtask

   initial begin
      CtrlRst = 1'b1;
      CpuReq = 1'b0; CpuWe = 1'b0; CpuAddr = 16'h0; CpuWData = 16'h0;
      DbgReq = 1'b0; DbgWe = 1'b0; DbgAddr = 16'h0; DbgWData = 16'h0;
      pokeEn = 1'b0; pokeAddr = 16'h0; pokeData = 16'h0;
      @(negedge CLK);
      runTable();
      runDirected();
      runRandom(600);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
